// File: rtl/ysyx_24100012_store_buffer.sv
// Store buffer: aligns byte/half/word/dword stores into memory-word lanes and
// queues them in a small FIFO. Misaligned stores are accepted but dropped.
module ysyx_24100012_store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_size,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [DATA_WIDTH-1:0]      req_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  output logic [DATA_WIDTH/8-1:0]    mem_wstrb,
  output logic                       misalign_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [STRB_W-1:0]     strb_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;

  logic [OFF_W-1:0]      offset;
  logic [7:0]            offset_ext;
  logic [7:0]            align_mask;
  logic [STRB_W-1:0]     size_mask;
  logic [STRB_W-1:0]     lane_strb;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  misaligned;
  logic                  enq;
  logic                  deq;

  assign offset     = req_addr[OFF_W-1:0];
  assign offset_ext = 8'(offset);
  assign word_addr  = req_addr & ~ADDR_WIDTH'(STRB_W - 1);

  always_comb begin
    size_mask  = '0;
    align_mask = 8'h00;
    case (req_size)
      2'b00: begin size_mask = STRB_W'(8'h01); align_mask = 8'h00; end
      2'b01: begin size_mask = STRB_W'(8'h03); align_mask = 8'h01; end
      2'b10: begin size_mask = STRB_W'(8'h0F); align_mask = 8'h03; end
      default: begin size_mask = STRB_W'(8'hFF); align_mask = 8'h07; end
    endcase
    // A dword cannot fit a 32-bit memory word, so it is always rejected there.
    misaligned = ((offset_ext & align_mask) != 8'h00) ||
                 ((req_size == 2'b11) && (DATA_WIDTH == 32));
    lane_strb  = size_mask << offset;
    lane_data  = req_data << {offset, 3'b000};
  end

  // Readiness looks only at the registered count, never at mem_ready.
  assign req_ready = (count_q < CNT_W'(DEPTH));
  assign enq       = req_valid && req_ready && !misaligned;
  assign deq       = (count_q != '0) && mem_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = req_valid && req_ready && misaligned;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q] <= word_addr;
      data_mem[wr_ptr_q] <= lane_data;
      strb_mem[wr_ptr_q] <= lane_strb;
    end
  end

  // Outputs are gated by empty so reset forces them to zero without a clock.
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign mem_valid    = !empty;
  assign misalign_err = misalign_q;
  assign mem_addr     = empty ? '0 : addr_mem[rd_ptr_q];
  assign mem_wdata    = empty ? '0 : data_mem[rd_ptr_q];
  assign mem_wstrb    = empty ? '0 : strb_mem[rd_ptr_q];

endmodule

// File: tb/tb_ysyx_24100012_store_buffer.sv
// Directed bench for the store buffer: a 32-bit instance checked through a
// scoreboard of expected drains, plus a 64-bit instance for dword lanes.
module tb_ysyx_24100012_store_buffer;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_size  = 2'b00;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_data  = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        misalign_err;
  logic [2:0]  count;
  logic        empty;

  logic        req_valid_64 = 1'b0;
  logic        req_ready_64;
  logic [1:0]  req_size_64  = 2'b00;
  logic [31:0] req_addr_64  = '0;
  logic [63:0] req_data_64  = '0;
  logic        mem_valid_64;
  logic        mem_ready_64 = 1'b0;
  logic [31:0] mem_addr_64;
  logic [63:0] mem_wdata_64;
  logic [7:0]  mem_wstrb_64;
  logic        misalign_err_64;
  logic [2:0]  count_64;
  logic        empty_64;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  ysyx_24100012_store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) u32 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .misalign_err(misalign_err),
    .count(count), .empty(empty)
  );

  ysyx_24100012_store_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(4)) u64 (
    .clk(clk), .rst(rst), .req_valid(req_valid_64), .req_ready(req_ready_64),
    .req_size(req_size_64), .req_addr(req_addr_64), .req_data(req_data_64),
    .mem_valid(mem_valid_64), .mem_ready(mem_ready_64), .mem_addr(mem_addr_64),
    .mem_wdata(mem_wdata_64), .mem_wstrb(mem_wstrb_64), .misalign_err(misalign_err_64),
    .count(count_64), .empty(empty_64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // Compare any drain happening at the upcoming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    #1;
    if (mem_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_drain", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", 64'(mem_addr), 64'(e.a));
        chk("sb_strb", 64'(mem_wstrb), 64'(e.s));
        chk("sb_wdata", 64'(mem_wdata & lane_mask(e.s)), 64'(e.w));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input bit mis, input logic [31:0] ew, input logic [3:0] es);
    int guard;
    exp_t e;
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    guard     = 0;
    #1;
    while (!req_ready && guard < 40) begin
      tick();
      guard++;
    end
    if (guard >= 40) chk("accept_timeout", 64'(req_ready), 64'(1));
    if (!mis) begin
      e.a = {a[31:2], 2'b00};
      e.w = ew;
      e.s = es;
      sb_q.push_back(e);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain_all();
    int guard;
    guard     = 0;
    mem_ready = 1'b1;
    while (!empty && guard < 40) begin
      tick();
      guard++;
    end
    mem_ready = 1'b0;
    chk("drain_empty", 64'(empty), 64'(1));
    chk("drain_sb_left", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    #3;
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_mem_valid", 64'(mem_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_misalign", 64'(misalign_err), 64'(0));
    #9 rst = 1'b1;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;

    // Byte store into the top lane, visible the cycle after acceptance.
    send(2'b00, 32'h1003, 32'hAB, 1'b0, 32'hAB00_0000, 4'h8);
    chk("sb_valid_next", 64'(mem_valid), 64'(1));
    chk("sb_mem_addr", 64'(mem_addr), 64'(32'h1000));
    chk("sb_mem_strb", 64'(mem_wstrb), 64'(4'h8));
    chk("sb_mem_byte", 64'(mem_wdata[31:24]), 64'(8'hAB));
    drain_all();

    send(2'b01, 32'h2002, 32'h1234, 1'b0, 32'h1234_0000, 4'hC);
    chk("sh_strb", 64'(mem_wstrb), 64'(4'hC));
    chk("sh_half", 64'(mem_wdata[31:16]), 64'(16'h1234));
    drain_all();

    send(2'b10, 32'h2001, 32'hCAFE_F00D, 1'b1, 32'h0, 4'h0);
    chk("sw_mis_pulse", 64'(misalign_err), 64'(1));
    chk("sw_mis_count", 64'(count), 64'(0));
    tick();
    chk("sw_mis_pulse_end", 64'(misalign_err), 64'(0));

    // Fill with memory stalled, then hold a fifth request across one drain.
    for (int i = 1; i <= 4; i++)
      send(2'b10, 32'h100 + 32'(4 * i), 32'(i), 1'b0, 32'(i), 4'hF);
    chk("full_count", 64'(count), 64'(4));
    chk("full_ready", 64'(req_ready), 64'(0));
    req_valid = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h114;
    req_data  = 32'd5;
    tick();
    chk("full_hold_ready", 64'(req_ready), 64'(0));
    chk("full_hold_count", 64'(count), 64'(4));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("after_pop_count", 64'(count), 64'(3));
    send(2'b10, 32'h114, 32'd5, 1'b0, 32'd5, 4'hF);
    chk("fifth_count", 64'(count), 64'(4));
    drain_all();

    // Simultaneous enqueue and dequeue, then enough traffic to wrap pointers.
    send(2'b10, 32'h200, 32'hA1, 1'b0, 32'hA1, 4'hF);
    send(2'b10, 32'h204, 32'hA2, 1'b0, 32'hA2, 4'hF);
    chk("two_count", 64'(count), 64'(2));
    mem_ready = 1'b1;
    send(2'b10, 32'h208, 32'hA3, 1'b0, 32'hA3, 4'hF);
    chk("enq_deq_count", 64'(count), 64'(2));
    for (int i = 0; i < 9; i++)
      send(2'b00, 32'h300 + 32'(i), 32'(8'h40 + i), 1'b0,
           32'(8'h40 + i) << (8 * (i % 4)), 4'(1 << (i % 4)));
    drain_all();

    // Reset with three entries pending and a misalign pulse in flight.
    for (int i = 0; i < 3; i++)
      send(2'b10, 32'h400 + 32'(4 * i), 32'h77 + 32'(i), 1'b0, 32'h77 + 32'(i), 4'hF);
    send(2'b01, 32'h401, 32'h5555, 1'b1, 32'h0, 4'h0);
    chk("pre_rst_count", 64'(count), 64'(3));
    chk("pre_rst_mis", 64'(misalign_err), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_mem_valid", 64'(mem_valid), 64'(0));
    chk("async_count", 64'(count), 64'(0));
    chk("async_misalign", 64'(misalign_err), 64'(0));
    chk("async_mem_addr", 64'(mem_addr), 64'(0));
    chk("async_mem_strb", 64'(mem_wstrb), 64'(0));
    sb_q.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rel_empty", 64'(empty), 64'(1));
    chk("rel_ready", 64'(req_ready), 64'(1));
    mem_ready = 1'b1;
    tick();
    chk("rel_still_empty", 64'(empty), 64'(1));
    mem_ready = 1'b0;

    // 64-bit memory word: full dword and an upper-lane word.
    req_valid_64 = 1'b1;
    req_size_64  = 2'b11;
    req_addr_64  = 32'h3000;
    req_data_64  = 64'h1122_3344_5566_7788;
    tick();
    req_valid_64 = 1'b0;
    chk("sd_valid", 64'(mem_valid_64), 64'(1));
    chk("sd_addr", 64'(mem_addr_64), 64'(32'h3000));
    chk("sd_strb", 64'(mem_wstrb_64), 64'(8'hFF));
    chk("sd_wdata", mem_wdata_64, 64'h1122_3344_5566_7788);
    mem_ready_64 = 1'b1;
    tick();
    mem_ready_64 = 1'b0;
    chk("sd_drained", 64'(empty_64), 64'(1));
    req_valid_64 = 1'b1;
    req_size_64  = 2'b10;
    req_addr_64  = 32'h3004;
    req_data_64  = 64'h0000_0000_DEAD_BEEF;
    tick();
    req_valid_64 = 1'b0;
    chk("sw64_addr", 64'(mem_addr_64), 64'(32'h3000));
    chk("sw64_strb", 64'(mem_wstrb_64), 64'(8'hF0));
    chk("sw64_upper", 64'(mem_wdata_64[63:32]), 64'(32'hDEAD_BEEF));
    chk("sw64_mis", 64'(misalign_err_64), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
